hsk_uart_tx: RTL and testbench
==============================

Name: hsk_uart_tx

Overview:
- Housekeeping UART transmitter driving the serial line to the TURFIO.
- Its line output feeds the housekeeping TX monitor input of the SURF ID/control block.
- Consumes that block's watchdog trigger and watchdog null outputs:
  - a null request forces the line low;
  - a trigger permanently disconnects the normal byte stream.
- Serialises 8N1 frames at 500 kbps from a 200 MHz wishbone-domain clock.

Parameters:
- CLKS_PER_BIT, 400, clocks per bit time; legal range 2..4095.
- GUARD_BITS, 1, idle-high bit times held after a null ends before new bytes are accepted.

Ports:
- wb_clk_i  in  1  200 MHz clock; all logic in this domain.
- wb_rst_ni  in  1  asynchronous active-low reset.
- s_tdata_i  in  8  byte to send; LSB first on the line.
- s_tvalid_i  in  1  byte valid.
- s_tready_o  out  1  byte accepted when s_tvalid_i && s_tready_o at a clock edge.
- watchdog_null_i  in  1  null request (level).
- watchdog_trigger_i  in  1  watchdog fired (sticky upstream).
- tx_o  out  1  serial line; idle high; registered.
- busy_o  out  1  high when state != IDLE.
- drop_count_o  out  8  bytes discarded since reset; saturates at 255.

Behaviour:
- Reset (async assert, sync release) values:
  - tx_o=1, s_tready_o=0, busy_o=0, drop_count_o=0, state=IDLE.
  - s_tready_o rises 1 cycle after reset release.
- States: IDLE, START, DATA, STOP, NULL, GUARD, DEAD.
- Bit timer: counts 0..CLKS_PER_BIT-1, reloaded to 0 on every state or bit change.
- IDLE:
  - tx_o=1, s_tready_o=1.
  - On handshake: latch s_tdata_i, go to START.
- START:
  - tx_o=0 starting the cycle after the handshake.
  - Lasts CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Bits 0..7, each CLKS_PER_BIT cycles; 3-bit bit index.
  - After bit 7, go to STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back frame period is 10*CLKS_PER_BIT+1 cycles; the 1 is the IDLE acceptance cycle.
- s_tready_o:
  - Low in START/DATA/STOP/NULL/GUARD.
  - High in IDLE and DEAD.
- Null handling (watchdog_null_i sampled high in any state except DEAD):
  - Next cycle go to NULL and drive tx_o=0; any frame in flight is aborted mid-bit.
  - The aborted byte counts as dropped.
  - Remain in NULL while watchdog_null_i is high.
  - On its deassertion go to GUARD: tx_o=1 for GUARD_BITS*CLKS_PER_BIT cycles, then IDLE.
- Trigger handling (watchdog_trigger_i high, any state):
  - Priority over null: null is still honoured for line level, but the byte path is lost.
  - If watchdog_null_i is high: tx_o=0 (NULL behaviour).
  - Otherwise go to DEAD: tx_o=1.
  - DEAD: s_tready_o=1; every handshake increments drop_count_o; no transmission.
  - DEAD exits only on reset.
- Simultaneous events:
  - Null and handshake in the same IDLE cycle: the byte is accepted and counted dropped; NULL is entered.
  - Null rising in the final cycle of STOP: treated as abort; the frame is counted dropped.
- drop_count_o: 8-bit saturating; it does not wrap.
- Reset mid-frame: line returns high asynchronously; no partial-frame recovery.

Optional Feature:
- Macro: HSK_UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between bit 7 and STOP (new state PARITY, tx_o = ^data, CLKS_PER_BIT cycles). Frame period becomes 11*CLKS_PER_BIT+1.
- Undefined: 8N1 only; PARITY state and parity logic absent.

Decomposition:
- Package hsk_pkg holds:
  - state enum type hsk_tx_state_t;
  - localparam HSK_DATA_BITS=8;
  - localparam HSK_DROP_W=8.
- One sub-module, hsk_bit_timer:
  - parameter CLKS_PER_BIT; inputs clear/enable;
  - outputs bit_done pulse on the last cycle of each bit;
  - reused by GUARD via a guard bit counter in the parent.

Test Plan (CLKS_PER_BIT=4, GUARD_BITS=1 unless noted):
- Reset then send 0xA5:
  - tx_o sequence per 4 clocks: 0,1,0,1,0,0,1,0,1,1;
  - s_tready_o low for 40 cycles, high again on cycle 41.
- Back-to-back 0x00, 0xFF with tvalid held: second start bit begins exactly 41 cycles after the first; drop_count_o=0.
- Null abort:
  - watchdog_null_i high for 20 cycles during DATA bit 3 of 0x3C;
  - tx_o=0 from the next cycle for 20 cycles, then high for 4;
  - tready returns; drop_count_o=1.
- Trigger:
  - watchdog_trigger_i high in IDLE, then push 300 bytes;
  - tx_o stays 1; all accepted; drop_count_o=255 (saturated).
- Trigger plus null: trigger high, then null high for 10 cycles; tx_o=0 for those 10 cycles, otherwise 1; state remains DEAD.
- Parity build: send 0x07 with HSK_UART_TX_PARITY_EN; parity bit=1; frame 44 cycles; next tready at cycle 45.

Source files
------------

// File: rtl/hsk_uart_tx_pkg.sv
// rtl/hsk_uart_tx_pkg.sv - shared types and constants for the housekeeping UART transmitter (HSK_UART_TX_PARITY_EN adds PARITY)
package hsk_pkg;

  localparam int HSK_DATA_BITS = 8;
  localparam int HSK_DROP_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_NULL  = 3'd4,
    ST_GUARD = 3'd5,
    ST_DEAD  = 3'd6
`ifdef HSK_UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd7
`endif
  } hsk_tx_state_t;

endpackage

// File: rtl/hsk_uart_tx_bit_timer.sv
// rtl/hsk_uart_tx_bit_timer.sv - bit-period timer, pulses bit_done on the last clock of each bit
module hsk_bit_timer #(
  parameter int CLKS_PER_BIT = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_done = enable && (cnt == CW'(CLKS_PER_BIT - 1));

  // Count clocks within the current bit; wrap at the bit boundary, restart on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hsk_uart_tx.sv
// rtl/hsk_uart_tx.sv - housekeeping UART transmitter with watchdog null/trigger handling (optional HSK_UART_TX_PARITY_EN)
module hsk_uart_tx
  import hsk_pkg::*;
#(
  parameter int CLKS_PER_BIT = 400,
  parameter int GUARD_BITS   = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [HSK_DATA_BITS-1:0] s_tdata_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  input  logic                     watchdog_null_i,
  input  logic                     watchdog_trigger_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [HSK_DROP_W-1:0]    drop_count_o
);

  localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;

  hsk_tx_state_t            state, state_n;
  logic [2:0]               bit_idx, bit_idx_n;
  logic [HSK_DATA_BITS-1:0] data_q, data_n;
  logic [GW-1:0]            guard_cnt, guard_cnt_n;
  logic                     drop_inc;
  logic                     tx_d, rdy_d;
  logic                     handshake;
  logic                     in_flight;
  logic                     timer_clear, timer_en, bit_done;

  assign handshake = s_tvalid_i && s_tready_o;
  assign busy_o    = (state != ST_IDLE);

`ifdef HSK_UART_TX_PARITY_EN
  assign in_flight = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
`else
  assign in_flight = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
`endif

  // Timer runs only in timed states and restarts whenever the state changes
  assign timer_en    = in_flight || (state == ST_GUARD);
  assign timer_clear = (state_n != state);

  hsk_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (timer_clear),
    .enable  (timer_en),
    .bit_done(bit_done)
  );

  // State register plus registered line and ready outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      data_q     <= '0;
      guard_cnt  <= '0;
      tx_o       <= 1'b1;
      s_tready_o <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      data_q     <= data_n;
      guard_cnt  <= guard_cnt_n;
      tx_o       <= tx_d;
      s_tready_o <= rdy_d;
    end
  end

  // Next state: DEAD is terminal, trigger beats null, null aborts any frame in flight
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    data_n      = data_q;
    guard_cnt_n = guard_cnt;
    drop_inc    = 1'b0;
    if (state == ST_DEAD) begin
      drop_inc = handshake;
    end else if (watchdog_trigger_i) begin
      state_n  = ST_DEAD;
      drop_inc = handshake || in_flight;
    end else if (watchdog_null_i) begin
      state_n  = ST_NULL;
      drop_inc = handshake || in_flight;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            data_n    = s_tdata_i;
            bit_idx_n = '0;
            state_n   = ST_START;
          end
        end
        ST_START: begin
          if (bit_done) state_n = ST_DATA;
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'(HSK_DATA_BITS - 1)) begin
`ifdef HSK_UART_TX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end
        end
`ifdef HSK_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) state_n = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (bit_done) state_n = ST_IDLE;
        end
        ST_NULL: begin
          guard_cnt_n = '0;
          state_n     = (GUARD_BITS == 0) ? ST_IDLE : ST_GUARD;
        end
        ST_GUARD: begin
          if (bit_done) begin
            if (guard_cnt == GW'(GUARD_BITS - 1)) state_n = ST_IDLE;
            else guard_cnt_n = guard_cnt + GW'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Line level and ready for the upcoming cycle, derived from the next state
  always_comb begin
    tx_d  = 1'b1;
    rdy_d = 1'b0;
    case (state_n)
      ST_IDLE:   rdy_d = 1'b1;
      ST_START:  tx_d  = 1'b0;
      ST_DATA:   tx_d  = data_n[bit_idx_n];
`ifdef HSK_UART_TX_PARITY_EN
      ST_PARITY: tx_d  = ^data_n;
`endif
      ST_NULL:   tx_d  = 1'b0;
      ST_DEAD: begin
        tx_d  = !watchdog_null_i;
        rdy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating count of bytes that never made it onto the line
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      drop_count_o <= '0;
    end else if (drop_inc && (drop_count_o != '1)) begin
      drop_count_o <= drop_count_o + HSK_DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_hsk_uart_tx.sv
// tb/tb_hsk_uart_tx.sv - self-checking bench for hsk_uart_tx (CLKS_PER_BIT=4, GUARD_BITS=1)
module tb_hsk_uart_tx;

  localparam int N  = 4;
  localparam int GB = 1;
`ifdef HSK_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       wb_clk_i  = 1'b0;
  logic       wb_rst_ni = 1'b0;
  logic [7:0] s_tdata   = 8'h00;
  logic       s_tvalid  = 1'b0;
  logic       wd_null   = 1'b0;
  logic       wd_trig   = 1'b0;
  logic       s_tready;
  logic       tx;
  logic       busy;
  logic [7:0] drop;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_drop = 0;

  hsk_uart_tx #(
    .CLKS_PER_BIT(N),
    .GUARD_BITS  (GB)
  ) dut (
    .wb_clk_i          (wb_clk_i),
    .wb_rst_ni         (wb_rst_ni),
    .s_tdata_i         (s_tdata),
    .s_tvalid_i        (s_tvalid),
    .s_tready_o        (s_tready),
    .watchdog_null_i   (wd_null),
    .watchdog_trigger_i(wd_trig),
    .tx_o              (tx),
    .busy_o            (busy),
    .drop_count_o      (drop)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected in frame slot (bit time) 'slot' for byte b
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return 1'(({24'd0, b} >> (slot - 1)) % 2);
    if (FB == 11 && slot == 9) return 1'($countones(b) % 2);
    return 1'b1;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Offer a byte at a negedge and wait (bounded) for tready; returns at the negedge after the handshake
  task automatic offer(input logic [7:0] b, input string tag);
    int budget;
    @(negedge wb_clk_i);
    s_tdata  = b;
    s_tvalid = 1'b1;
    budget   = 200;
    while (s_tready !== 1'b1 && budget > 0) begin
      @(negedge wb_clk_i);
      budget--;
    end
    check({tag, "_hs_timeout"}, 32'(budget > 0), 32'd1);
    @(negedge wb_clk_i);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b);
    int mism[FB];
    int rdy_bad;
    rdy_bad = 0;
    for (int s = 0; s < FB; s++) mism[s] = 0;
    offer(b, "frame");
    for (int k = 0; k < FB * N; k++) begin
      if (k > 0) @(negedge wb_clk_i);
      if (tx !== exp_bit(b, k / N)) mism[k / N]++;
      if (s_tready !== 1'b0) rdy_bad++;
    end
    for (int s = 0; s < FB; s++)
      check($sformatf("frame_%02h_slot%0d_bad_cycles", b, s), 32'(mism[s]), 32'd0);
    check("frame_tready_low_cycles_bad", 32'(rdy_bad), 32'd0);
    @(negedge wb_clk_i);
    check("frame_tready_return", 32'(s_tready), 32'd1);
  endtask

  initial begin
    int bad, budget, sent, t1, t2;
    logic [7:0] rb;

    // Reset values
    repeat (3) @(negedge wb_clk_i);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check("tready_after_release", 32'(s_tready), 32'd1);

    // Directed and random frames
    send_frame(8'hA5);
    send_frame(8'h07);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      send_frame(rb);
    end
    check("drop_after_frames", 32'(drop), 32'(exp_drop));

    // Back-to-back 0x00 then 0xFF with tvalid held
    @(negedge wb_clk_i);
    s_tdata  = 8'h00;
    s_tvalid = 1'b1;
    budget   = 200;
    while (s_tready !== 1'b1 && budget > 0) begin
      @(negedge wb_clk_i);
      budget--;
    end
    @(negedge wb_clk_i);
    s_tdata = 8'hFF;
    t1 = cyc;
    check("b2b_first_start", 32'(tx), 32'd0);
    budget = 200;
    while (tx !== 1'b1 && budget > 0) begin
      @(negedge wb_clk_i);
      budget--;
    end
    while (tx !== 1'b0 && budget > 0) begin
      @(negedge wb_clk_i);
      budget--;
    end
    s_tvalid = 1'b0;
    t2 = cyc;
    check("b2b_timeout", 32'(budget > 0), 32'd1);
    check("b2b_start_spacing", 32'(t2 - t1), 32'(FB * N + 1));
    budget = 200;
    while (s_tready !== 1'b1 && budget > 0) begin
      @(negedge wb_clk_i);
      budget--;
    end
    check("b2b_drop", 32'(drop), 32'(exp_drop));

    // Null abort during data bit 3 of 0x3C
    offer(8'h3C, "null");
    repeat (17) @(negedge wb_clk_i);
    check("null_pre_bit3", 32'(tx), 32'(exp_bit(8'h3C, 4)));
    wd_null = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (tx !== 1'b0 || s_tready !== 1'b0) bad++;
    end
    wd_null  = 1'b0;
    exp_drop = sat_add(exp_drop, 1);
    check("null_low_bad_cycles", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < GB * N; i++) begin
      @(negedge wb_clk_i);
      if (tx !== 1'b1 || s_tready !== 1'b0) bad++;
    end
    check("guard_bad_cycles", 32'(bad), 32'd0);
    @(negedge wb_clk_i);
    check("guard_tready_return", 32'(s_tready), 32'd1);
    check("null_drop", 32'(drop), 32'(exp_drop));

    // Reset in the middle of a frame
    offer(8'h00, "midrst");
    repeat (9) @(negedge wb_clk_i);
    check("midrst_tx_low", 32'(tx), 32'd0);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("midrst_tx_high", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_drop", 32'(drop), 32'd0);
    exp_drop = 0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_tready", 32'(s_tready), 32'd1);

    // Trigger: 300 bytes swallowed, counter saturates, line stays idle
    @(negedge wb_clk_i);
    wd_trig  = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'($urandom);
    sent     = 0;
    budget   = 1000;
    bad      = 0;
    while (sent < 300 && budget > 0) begin
      if (s_tready === 1'b1) sent++;
      @(negedge wb_clk_i);
      budget--;
      if (tx !== 1'b1) bad++;
      s_tdata = 8'($urandom);
    end
    s_tvalid = 1'b0;
    exp_drop = sat_add(exp_drop, 300);
    check("trig_accepted", 32'(sent), 32'd300);
    check("trig_tx_low_cycles", 32'(bad), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    check("trig_drop_sat", 32'(drop), 32'(exp_drop));
    check("trig_busy", 32'(busy), 32'd1);
    check("trig_tready", 32'(s_tready), 32'd1);

    // Trigger plus null: line follows null, state stays dead
    check("dead_tx_idle", 32'(tx), 32'd1);
    wd_null = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      if (tx !== 1'b0 || s_tready !== 1'b1) bad++;
    end
    wd_null = 1'b0;
    check("dead_null_bad_cycles", 32'(bad), 32'd0);
    @(negedge wb_clk_i);
    check("dead_tx_release", 32'(tx), 32'd1);
    check("dead_busy", 32'(busy), 32'd1);
    check("dead_drop", 32'(drop), 32'(exp_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
